branch_predict_unit: RTL and testbench

//  Parametrised branch unit replacing the combinational beq-only PC-select path.

---
 rtl/branch_predict_unit_if.sv | 40 ++++
 rtl/branch_predict_unit.sv | 118 +++++++++++
 tb/tb_branch_predict_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute bundle between the pipeline and the branch predict unit.
interface branch_predict_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IMM_W = 16
) ();
   // fetch side
   logic             if_valid;
   logic             if_is_branch;
   logic [WIDTH-1:0] if_pc;
   logic [IMM_W-1:0] if_imm;
   logic             pred_taken;
   logic [WIDTH-1:0] pred_pc;
   // execute side
   logic             ex_valid;
   logic             ex_branch;
   logic             ex_bne;
   logic             ex_zero;
   logic [WIDTH-1:0] ex_pc;
   logic [IMM_W-1:0] ex_imm;
   logic             ex_pred_taken;
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             pc_src;
   logic [31:0]      branch_cnt;
   logic [31:0]      mispred_cnt;

   // pipeline side
   modport master (
      output if_valid, if_is_branch, if_pc, if_imm,
      output ex_valid, ex_branch, ex_bne, ex_zero, ex_pc, ex_imm, ex_pred_taken,
      input  pred_taken, pred_pc, redirect, redirect_pc, pc_src, branch_cnt, mispred_cnt
   );

   // predictor side
   modport slave (
      input  if_valid, if_is_branch, if_pc, if_imm,
      input  ex_valid, ex_branch, ex_bne, ex_zero, ex_pc, ex_imm, ex_pred_taken,
      output pred_taken, pred_pc, redirect, redirect_pc, pc_src, branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit counter table read at fetch, trained at execute,
// with a registered redirect on mispredict and branch/mispredict statistics.
module branch_predict_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned IMM_W     = 16,
   parameter int unsigned SHIFT     = 2,
   parameter int unsigned BHT_DEPTH = 64
) (
   input logic                   clk_i,
   input logic                   reset_i,
   branch_predict_unit_if.slave  bus_io
);
   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
   localparam logic [WIDTH-1:0] PcInc = WIDTH'(4);

   logic [1:0]       bht_q [BHT_DEPTH];

   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [WIDTH-1:0] if_off, ex_off;
   logic [WIDTH-1:0] if_target, ex_target;
   logic [WIDTH-1:0] if_fall, ex_fall;
   logic [1:0]       ex_ctr;
   logic [1:0]       ex_ctr_upd;
   logic             resolve;
   logic             actual;
   logic             mispred;

   logic             redirect_q, redirect_d;
   logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic             pc_src_q, pc_src_d;
   logic [31:0]      branch_cnt_q, branch_cnt_d;
   logic [31:0]      mispred_cnt_q, mispred_cnt_d;

   // Address arithmetic for both slots: sign-extended, scaled offset; wraps mod 2^WIDTH.
   always_comb begin
      if_idx    = bus_io.if_pc[IDX_W+1:2];
      ex_idx    = bus_io.ex_pc[IDX_W+1:2];
      if_off    = {{(WIDTH-IMM_W){bus_io.if_imm[IMM_W-1]}}, bus_io.if_imm} << SHIFT;
      ex_off    = {{(WIDTH-IMM_W){bus_io.ex_imm[IMM_W-1]}}, bus_io.ex_imm} << SHIFT;
      if_fall   = bus_io.if_pc + PcInc;
      ex_fall   = bus_io.ex_pc + PcInc;
      if_target = if_fall + if_off;
      ex_target = ex_fall + ex_off;
   end

   // Fetch prediction reads the table directly, so a same-cycle write is not bypassed.
   always_comb begin
      bus_io.pred_taken = bus_io.if_valid & bus_io.if_is_branch & bht_q[if_idx][1];
      bus_io.pred_pc    = bus_io.pred_taken ? if_target : if_fall;
   end

   // Resolve outcome and saturating counter update.
   always_comb begin
      resolve    = bus_io.ex_valid & bus_io.ex_branch;
      actual     = bus_io.ex_bne ? ~bus_io.ex_zero : bus_io.ex_zero;
      mispred    = resolve & (actual != bus_io.ex_pred_taken);
      ex_ctr     = bht_q[ex_idx];
      ex_ctr_upd = ex_ctr;
      if (actual && ex_ctr != 2'b11) begin
         ex_ctr_upd = ex_ctr + 2'b01;
      end else if (!actual && ex_ctr != 2'b00) begin
         ex_ctr_upd = ex_ctr - 2'b01;
      end
   end

   // Next-state for redirect, outcome and statistics registers.
   always_comb begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      pc_src_d      = pc_src_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolve) begin
         pc_src_d     = actual;
         branch_cnt_d = branch_cnt_q + 32'd1;
         if (mispred) begin
            redirect_d    = 1'b1;
            redirect_pc_d = actual ? ex_target : ex_fall;
            mispred_cnt_d = mispred_cnt_q + 32'd1;
         end
      end
   end

   // Table training; reset returns every entry to weak not-taken.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (resolve) begin
         bht_q[ex_idx] <= ex_ctr_upd;
      end
   end

   // Redirect and statistics registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         pc_src_q      <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         pc_src_q      <= pc_src_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bus_io.redirect    = redirect_q;
   assign bus_io.redirect_pc = redirect_pc_q;
   assign bus_io.pc_src      = pc_src_q;
   assign bus_io.branch_cnt  = branch_cnt_q;
   assign bus_io.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed cases plus random traffic against a
// table-of-integers reference model; registered outputs go through a scoreboard.
module tb_branch_predict_unit;
   logic clk;
   logic reset;

   branch_predict_unit_if #(.WIDTH(32), .IMM_W(16)) bus ();

   branch_predict_unit #(
      .WIDTH(32), .IMM_W(16), .SHIFT(2), .BHT_DEPTH(64)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_io  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        red;
      logic [31:0] rpc;
      logic        psrc;
      logic [31:0] bcnt;
      logic [31:0] mcnt;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   // reference model state
   int          m_ctr [64];
   logic        m_red;
   logic [31:0] m_rpc;
   logic        m_psrc;
   logic [31:0] m_bcnt;
   logic [31:0] m_mcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] tgt(input logic [31:0] pc, input logic [15:0] imm);
      longint off;
      off = longint'(imm);
      if (off >= 32768) off = off - 65536;
      return 32'(longint'(pc) + 4 + off * 4);
   endfunction

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_ctr[idx_of(pc)] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_red = 0; m_rpc = 0; m_psrc = 0; m_bcnt = 0; m_mcnt = 0;
   endtask

   // One cycle of stimulus: drive, check fetch prediction, advance the model, push expectation.
   task automatic step(input bit rst, input bit ifv, input bit ifb, input logic [31:0] ifpc,
                       input logic [15:0] ifimm, input bit exv, input bit exb, input bit bne,
                       input bit zero, input logic [31:0] expc, input logic [15:0] eximm,
                       input bit predt);
      bit          p;
      bit          act;
      exp_t        e;
      @(negedge clk);
      reset = rst;
      bus.if_valid = ifv; bus.if_is_branch = ifb; bus.if_pc = ifpc; bus.if_imm = ifimm;
      bus.ex_valid = exv; bus.ex_branch = exb; bus.ex_bne = bne; bus.ex_zero = zero;
      bus.ex_pc = expc; bus.ex_imm = eximm; bus.ex_pred_taken = predt;
      #1;
      p = ifv && ifb && m_pred(ifpc);
      chk("pred_taken", 32'(bus.pred_taken), 32'(p));
      chk("pred_pc", bus.pred_pc, p ? tgt(ifpc, ifimm) : ifpc + 32'd4);
      if (rst) begin
         model_reset();
      end else if (exv && exb) begin
         act = bne ? !zero : zero;
         if (act) m_ctr[idx_of(expc)] = (m_ctr[idx_of(expc)] == 3) ? 3 : m_ctr[idx_of(expc)] + 1;
         else     m_ctr[idx_of(expc)] = (m_ctr[idx_of(expc)] == 0) ? 0 : m_ctr[idx_of(expc)] - 1;
         m_bcnt = m_bcnt + 1;
         m_psrc = act;
         if (act != predt) begin
            m_mcnt = m_mcnt + 1;
            m_red  = 1;
            m_rpc  = act ? tgt(expc, eximm) : expc + 32'd4;
         end else begin
            m_red = 0;
         end
      end else begin
         m_red = 0;
      end
      e.red = m_red; e.rpc = m_rpc; e.psrc = m_psrc; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
      sb.push_back(e);
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [15:0] imm);
      step(0, 1, 1, pc, imm, 0, 0, 0, 0, 32'h0, 16'h0, 0);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [15:0] imm, input bit bne,
                          input bit zero, input bit predt);
      step(0, 0, 0, 32'h0, 16'h0, 1, 1, bne, zero, pc, imm, predt);
   endtask

   // Scoreboard monitor: after each rising edge, compare registered outputs to the next entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("redirect", 32'(bus.redirect), 32'(e.red));
            chk("redirect_pc", bus.redirect_pc, e.rpc);
            chk("pc_src", 32'(bus.pc_src), 32'(e.psrc));
            chk("branch_cnt", bus.branch_cnt, e.bcnt);
            chk("mispred_cnt", bus.mispred_cnt, e.mcnt);
         end
      end
   end

   initial begin
      logic [31:0] pc;
      logic [15:0] imm;
      bit          exv;
      reset = 1'b1;
      bus.if_valid = 0; bus.if_is_branch = 0; bus.if_pc = 0; bus.if_imm = 0;
      bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_bne = 0; bus.ex_zero = 0;
      bus.ex_pc = 0; bus.ex_imm = 0; bus.ex_pred_taken = 0;
      model_reset();
      repeat (2) @(posedge clk);
      step(1, 0, 0, 32'h0, 16'h0, 0, 0, 0, 0, 32'h0, 16'h0, 0);

      // reset state prediction
      fetch(32'h40, 16'h3);
      // BEQ mispredict, then refetch sees weak-taken
      resolve(32'h40, 16'h3, 0, 1, 0);
      fetch(32'h40, 16'h3);
      // BNE saturation at 0x80, backward target 0x7C
      resolve(32'h80, 16'hFFFE, 1, 0, 0);
      resolve(32'h80, 16'hFFFE, 1, 0, 1);
      resolve(32'h80, 16'hFFFE, 1, 0, 1);
      repeat (3) resolve(32'h80, 16'hFFFE, 1, 0, 1);
      fetch(32'h80, 16'hFFFE);
      // same-index read/write: fetch sees old counter, new one visible next cycle
      step(0, 1, 1, 32'h40, 16'h3, 1, 1, 0, 0, 32'h40, 16'h3, 1);
      fetch(32'h40, 16'h3);
      // ex_branch=0 / ex_valid=0 cause no change
      step(0, 1, 1, 32'h80, 16'hFFFE, 1, 0, 0, 0, 32'h80, 16'hFFFE, 0);
      step(0, 1, 1, 32'h80, 16'hFFFE, 0, 1, 0, 0, 32'h80, 16'hFFFE, 0);
      fetch(32'h80, 16'hFFFE);
      // reset overrides a mispredicting resolve
      step(1, 0, 0, 32'h0, 16'h0, 1, 1, 0, 1, 32'h80, 16'h3, 0);
      for (int i = 0; i < 64; i++) fetch(32'(i * 4), 16'h10);
      // PC wrap
      resolve(32'hFFFFFFFC, 16'h1, 0, 1, 0);
      resolve(32'hFFFFFFFC, 16'h1, 0, 1, 0);
      fetch(32'hFFFFFFFC, 16'h1);

      // random traffic over a small, colliding PC space
      for (int n = 0; n < 400; n++) begin
         pc  = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) pc = pc | 32'hFFFFFE00;
         imm = 16'($urandom());
         exv = $urandom_range(0, 3) != 0;
         step($urandom_range(0, 99) == 0, 1'($urandom()), 1'($urandom()),
              32'($urandom_range(0, 127)) << 2, 16'($urandom()),
              exv, $urandom_range(0, 7) != 0, 1'($urandom()), 1'($urandom()), pc, imm,
              ($urandom_range(0, 3) == 0) ? 1'($urandom()) : m_pred(pc));
      end

      step(0, 0, 0, 32'h0, 16'h0, 0, 0, 0, 0, 32'h0, 16'h0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
